// File: rtl/pipeline_job_sequencer_pkg.sv
// Shared types and widths for the pipeline job sequencer.
// Holds the FSM state encoding and the fixed data widths of the permutation pipeline.
package pipeline_job_sequencer_pkg;

   localparam int unsigned TopWidth      = 128;
   localparam int unsigned BotWidth      = 128;
   localparam int unsigned ResSumWidth   = 48;
   localparam int unsigned ResCountWidth = 13;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StFeed,
      StDrain,
      StDone
   } seq_state_e;

endpackage

// File: rtl/sequencer_credit_counter.sv
// Up/down counter of bots written into the pipeline but not yet retired by a result grab.
// Provides full/empty flags used to gate bot writes and result grabs.
module sequencer_credit_counter #(
   parameter int unsigned MaxCount   = 32,
   parameter int unsigned CountWidth = $clog2(MaxCount) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inc_i,
   input  logic                  dec_i,
   output logic [CountWidth-1:0] count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic [CountWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      case ({inc_i, dec_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = (count_q == CountWidth'(MaxCount));
   assign empty_o = (count_q == '0);

   credit_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (full_o && inc_i) |-> dec_i);
   credit_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(empty_o && dec_i));
   credit_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CountWidth'(MaxCount));

endmodule

// File: rtl/pipeline_job_sequencer.sv
// Job controller in front of one permutation pipeline: holds the top, streams bots under a
// credit limit, retires results from the pipeline output FIFO and accumulates the job total.
module pipeline_job_sequencer
   import pipeline_job_sequencer_pkg::*;
#(
   parameter int unsigned BOT_COUNT_WIDTH = 16,
   parameter int unsigned MAX_OUTSTANDING = 32,
   parameter int unsigned TOP_SETTLE      = 4,
   localparam int unsigned OutW           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   jobStart,
   input  logic [TopWidth-1:0]                    jobTop,
   input  logic [BOT_COUNT_WIDTH-1:0]             jobBotCount,
   output logic                                   jobReady,
   input  logic [BotWidth-1:0]                    botIn,
   input  logic                                   botInValid,
   output logic                                   botInReady,
   output logic [TopWidth-1:0]                    pipeTop,
   output logic [BotWidth-1:0]                    pipeBot,
   output logic                                   pipeWriteBot,
   input  logic                                   pipeReadyForInputBot,
   input  logic                                   pipeResultsAvailable,
   output logic                                   pipeGrabResults,
   input  logic [ResSumWidth-1:0]                 pipePcoeffSum,
   input  logic [ResCountWidth-1:0]               pipePcoeffCount,
   input  logic                                   pipeEccStatus,
   output logic                                   jobDone,
   output logic [ResSumWidth+BOT_COUNT_WIDTH-1:0] jobSum,
   output logic [ResCountWidth+BOT_COUNT_WIDTH-1:0] jobCountSum,
   output logic                                   jobEccError,
   output logic [OutW-1:0]                        outstanding
);

   localparam int unsigned SettleW = (TOP_SETTLE > 1) ? $clog2(TOP_SETTLE) : 1;
   localparam int unsigned SumW    = ResSumWidth + BOT_COUNT_WIDTH;
   localparam int unsigned CsumW   = ResCountWidth + BOT_COUNT_WIDTH;

   seq_state_e                 state_q, state_d;
   logic [TopWidth-1:0]        top_q, top_d;
   logic [BotWidth-1:0]        bot_q, bot_d;
   logic [BOT_COUNT_WIDTH-1:0] count_q, count_d;
   logic [BOT_COUNT_WIDTH-1:0] bots_sent_q, bots_sent_d;
   logic [BOT_COUNT_WIDTH-1:0] results_got_q, results_got_d;
   logic [SettleW-1:0]         settle_q, settle_d;
   logic [SumW-1:0]            sum_q, sum_d;
   logic [CsumW-1:0]           csum_q, csum_d;
   logic                       ecc_q, ecc_d;
   logic                       write_q, write_d;
   logic                       grab_q, grab_d;
   logic                       done_q, done_d;

   logic credit_full, credit_empty;
   logic retiring, grab, xfer;

   assign retiring   = (state_q == StFeed) || (state_q == StDrain);
   assign botInReady = (state_q == StFeed) && pipeReadyForInputBot && !credit_full &&
                       (bots_sent_q < count_q);
   assign xfer       = botInValid && botInReady;
   // Grabs are spaced by one idle cycle so the FIFO flag can settle after each read.
   assign grab       = retiring && pipeResultsAvailable && !credit_empty && !grab_q;

   sequencer_credit_counter #(
      .MaxCount   (MAX_OUTSTANDING),
      .CountWidth (OutW)
   ) u_credit (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (xfer),
      .dec_i   (grab),
      .count_o (outstanding),
      .full_o  (credit_full),
      .empty_o (credit_empty)
   );

   always_comb begin
      state_d       = state_q;
      top_d         = top_q;
      bot_d         = bot_q;
      count_d       = count_q;
      bots_sent_d   = bots_sent_q;
      results_got_d = results_got_q;
      settle_d      = settle_q;
      sum_d         = sum_q;
      csum_d        = csum_q;
      ecc_d         = ecc_q;
      write_d       = 1'b0;
      grab_d        = grab;
      done_d        = 1'b0;

      if (xfer) begin
         bot_d       = botIn;
         write_d     = 1'b1;
         bots_sent_d = bots_sent_q + 1'b1;
      end

      // Result data from the pipeline is valid the cycle after the grab strobe.
      if (grab_q) begin
         sum_d         = sum_q + {{BOT_COUNT_WIDTH{1'b0}}, pipePcoeffSum};
         csum_d        = csum_q + {{BOT_COUNT_WIDTH{1'b0}}, pipePcoeffCount};
         ecc_d         = ecc_q | pipeEccStatus;
         results_got_d = results_got_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (jobStart) begin
               top_d         = jobTop;
               count_d       = jobBotCount;
               bots_sent_d   = '0;
               results_got_d = '0;
               settle_d      = '0;
               sum_d         = '0;
               csum_d        = '0;
               ecc_d         = 1'b0;
               state_d       = StSettle;
            end
         end
         StSettle: begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SettleW'(TOP_SETTLE - 1)) begin
               state_d = (count_q == '0) ? StDone : StFeed;
            end
         end
         StFeed: begin
            if (bots_sent_q == count_q) state_d = StDrain;
         end
         StDrain: begin
            if (results_got_q == count_q) state_d = StDone;
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         top_q         <= '0;
         bot_q         <= '0;
         count_q       <= '0;
         bots_sent_q   <= '0;
         results_got_q <= '0;
         settle_q      <= '0;
         sum_q         <= '0;
         csum_q        <= '0;
         ecc_q         <= 1'b0;
         write_q       <= 1'b0;
         grab_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         top_q         <= top_d;
         bot_q         <= bot_d;
         count_q       <= count_d;
         bots_sent_q   <= bots_sent_d;
         results_got_q <= results_got_d;
         settle_q      <= settle_d;
         sum_q         <= sum_d;
         csum_q        <= csum_d;
         ecc_q         <= ecc_d;
         write_q       <= write_d;
         grab_q        <= grab_d;
         done_q        <= done_d;
      end
   end

   assign jobReady        = (state_q == StIdle);
   assign pipeTop         = top_q;
   assign pipeBot         = bot_q;
   assign pipeWriteBot    = write_q;
   assign pipeGrabResults = grab;
   assign jobDone         = done_q;
   assign jobSum          = sum_q;
   assign jobCountSum     = csum_q;
   assign jobEccError     = ecc_q;

endmodule

// File: tb/tb_pipeline_job_sequencer.sv
// Directed bench for pipeline_job_sequencer: table of whole jobs plus hand-written sequences
// for credit limiting, zero-bot latency, async reset mid-job and jobStart while busy.
module tb_pipeline_job_sequencer;

   localparam int unsigned BCW    = 16;
   localparam int unsigned MAXO   = 4;
   localparam int unsigned SETTLE = 4;
   localparam int          BIG    = 1 << 30;

   logic           clk, rst_n, jobStart, jobReady;
   logic [127:0]   jobTop, botIn, pipeTop, pipeBot;
   logic [BCW-1:0] jobBotCount;
   logic           botInValid, botInReady, pipeWriteBot, pipeReadyForInputBot;
   logic           pipeResultsAvailable, pipeGrabResults, pipeEccStatus;
   logic [47:0]    pipePcoeffSum;
   logic [12:0]    pipePcoeffCount;
   logic           jobDone, jobEccError;
   logic [63:0]    jobSum;
   logic [28:0]    jobCountSum;
   logic [2:0]     outstanding;

   pipeline_job_sequencer #(
      .BOT_COUNT_WIDTH (BCW),
      .MAX_OUTSTANDING (MAXO),
      .TOP_SETTLE      (SETTLE)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .jobStart             (jobStart),
      .jobTop               (jobTop),
      .jobBotCount          (jobBotCount),
      .jobReady             (jobReady),
      .botIn                (botIn),
      .botInValid           (botInValid),
      .botInReady           (botInReady),
      .pipeTop              (pipeTop),
      .pipeBot              (pipeBot),
      .pipeWriteBot         (pipeWriteBot),
      .pipeReadyForInputBot (pipeReadyForInputBot),
      .pipeResultsAvailable (pipeResultsAvailable),
      .pipeGrabResults      (pipeGrabResults),
      .pipePcoeffSum        (pipePcoeffSum),
      .pipePcoeffCount      (pipePcoeffCount),
      .pipeEccStatus        (pipeEccStatus),
      .jobDone              (jobDone),
      .jobSum               (jobSum),
      .jobCountSum          (jobCountSum),
      .jobEccError          (jobEccError),
      .outstanding          (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pipeline model: one result per written bot, released up to rel_limit.
   int          wr_total = 0;
   int          res_rd   = 0;
   int          rel_limit = 0;
   logic [47:0] res_sum [0:255];
   logic [12:0] res_cnt [0:255];
   logic        res_ecc [0:255];

   assign pipeResultsAvailable = (res_rd < wr_total) && (res_rd < rel_limit);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_rd          <= wr_total;
         pipePcoeffSum   <= '0;
         pipePcoeffCount <= '0;
         pipeEccStatus   <= 1'b0;
      end else begin
         if (pipeWriteBot) wr_total <= wr_total + 1;
         if (pipeGrabResults) begin
            pipePcoeffSum   <= res_sum[res_rd];
            pipePcoeffCount <= res_cnt[res_rd];
            pipeEccStatus   <= res_ecc[res_rd];
            res_rd          <= res_rd + 1;
         end
      end
   end

   // Monitors, sampled on the falling edge.
   int           n_wr = 0, n_done = 0, n_consec = 0, n_badx = 0, n_topchg = 0;
   logic         last_grab = 1'b0, last_busy = 1'b0;
   logic [127:0] last_top = '0;
   logic [127:0] bot_log [0:255];

   always @(negedge clk) begin
      if (pipeWriteBot) begin
         bot_log[n_wr] <= pipeBot;
         n_wr          <= n_wr + 1;
      end
      if (jobDone) n_done <= n_done + 1;
      if (pipeGrabResults && last_grab) n_consec <= n_consec + 1;
      if (botInReady && !pipeReadyForInputBot) n_badx <= n_badx + 1;
      if (last_busy && !jobReady && pipeTop != last_top) n_topchg <= n_topchg + 1;
      last_grab <= pipeGrabResults;
      last_busy <= !jobReady;
      last_top  <= pipeTop;
   end

   function automatic logic [127:0] bot_val(input logic [127:0] t, input int i);
      return {t[63:0], t[127:64]} ^ {96'h0, 32'(i) + 32'h1000};
   endfunction

   // Bot source: restarts at bot 0 whenever feed_gen changes.
   int           feed_n = 0, feed_gen = 0;
   logic [127:0] feed_top = '0;
   bit           feed_toggle = 1'b0;

   initial begin : feeder
      int idx;
      int seen;
      bit xfer;
      idx = 0;
      seen = 0;
      botInValid = 1'b0;
      botIn = '0;
      pipeReadyForInputBot = 1'b1;
      forever begin
         @(negedge clk);
         xfer = botInValid && botInReady;
         @(posedge clk);
         #1;
         if (feed_gen != seen) begin
            seen = feed_gen;
            idx  = 0;
         end else if (xfer) begin
            idx++;
         end
         botInValid = (idx < feed_n);
         botIn      = bot_val(feed_top, idx);
         pipeReadyForInputBot = feed_toggle ? !pipeReadyForInputBot : 1'b1;
      end
   end

   typedef struct {
      logic [127:0] top;
      int           nbots;
      logic [47:0]  base;
      bit           toggle;
      int           ecc_at;
      logic [63:0]  exp_sum;
      logic [28:0]  exp_cnt;
      bit           exp_ecc;
   } vec_t;

   vec_t vecs [0:4];
   int   n_vec = 0, n_bad = 0;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic fill(input int n, input logic [47:0] base, input int ecc_at);
      logic [63:0] p;
      for (int i = 0; i < n; i++) begin
         p = 64'(base) * 64'(i + 1);
         res_sum[wr_total + i] = p[47:0];
         res_cnt[wr_total + i] = 13'(i + 1);
         res_ecc[wr_total + i] = (i == ecc_at);
      end
   endtask

   task automatic start_job(input logic [127:0] top, input int n, input bit toggle);
      feed_top    = top;
      feed_n      = n;
      feed_toggle = toggle;
      feed_gen++;
      jobStart    = 1'b1;
      jobTop      = top;
      jobBotCount = BCW'(n);
      step();
      jobStart    = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int c;
      c = 0;
      while (jobDone !== 1'b1 && c < budget) begin
         step();
         c++;
      end
      ok = (jobDone === 1'b1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int d_done, d_wr, d_consec, d_badx, d_top, mism;
      bit ok;
      d_done = n_done; d_wr = n_wr; d_consec = n_consec; d_badx = n_badx; d_top = n_topchg;
      fill(v.nbots, v.base, v.ecc_at);
      rel_limit = BIG;
      start_job(v.top, v.nbots, v.toggle);
      wait_done(400, ok);
      chk({tag, "_done_seen"}, 128'(ok), 128'd1);
      step();
      mism = 0;
      for (int i = 0; i < v.nbots; i++) begin
         if (bot_log[d_wr + i] !== bot_val(v.top, i)) mism++;
      end
      chk({tag, "_sum"}, 128'(jobSum), 128'(v.exp_sum));
      chk({tag, "_count_sum"}, 128'(jobCountSum), 128'(v.exp_cnt));
      chk({tag, "_ecc"}, 128'(jobEccError), 128'(v.exp_ecc));
      chk({tag, "_done_pulses"}, 128'(n_done - d_done), 128'd1);
      chk({tag, "_writes"}, 128'(n_wr - d_wr), 128'(v.nbots));
      chk({tag, "_bot_data_errs"}, 128'(mism), 128'd0);
      chk({tag, "_consec_grabs"}, 128'(n_consec - d_consec), 128'd0);
      chk({tag, "_xfer_not_ready"}, 128'(n_badx - d_badx), 128'd0);
      chk({tag, "_top_changes"}, 128'(n_topchg - d_top), 128'd0);
      chk({tag, "_pipe_top"}, pipeTop, v.top);
      chk({tag, "_outstanding"}, 128'(outstanding), 128'd0);
      chk({tag, "_ready"}, 128'(jobReady), 128'd1);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      int d_done, d_wr, lat;
      bit ok;
      vec_t v2;

      vecs[0] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3, 48'd10, 1'b0, -1,
                  64'd60, 29'd6, 1'b0};
      vecs[1] = '{128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0, 5, 48'd7, 1'b1, 2,
                  64'd105, 29'd15, 1'b1};
      vecs[2] = '{128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 48'd9, 1'b0, -1,
                  64'd0, 29'd0, 1'b0};
      vecs[3] = '{128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 10, 48'd1000, 1'b0, -1,
                  64'd55000, 29'd55, 1'b0};
      vecs[4] = '{128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_C0DE, 2, 48'h7FFF_FFFF_FFFF, 1'b1, 1,
                  64'h1_7FFF_FFFF_FFFD, 29'd3, 1'b1};

      rst_n = 1'b0; jobStart = 1'b0; jobTop = '0; jobBotCount = '0;
      step();
      step();
      chk("rst_ready", 128'(jobReady), 128'd1);
      chk("rst_done", 128'(jobDone), 128'd0);
      chk("rst_outstanding", 128'(outstanding), 128'd0);
      chk("rst_write", 128'(pipeWriteBot), 128'd0);
      chk("rst_grab", 128'(pipeGrabResults), 128'd0);
      chk("rst_top", pipeTop, 128'd0);
      chk("rst_sum", 128'(jobSum), 128'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Zero-bot job: done pulse TOP_SETTLE+2 cycles after the jobStart cycle.
      d_wr = n_wr;
      feed_n = 0; feed_gen++;
      jobStart = 1'b1; jobTop = 128'h77; jobBotCount = '0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #2;
         jobStart = 1'b0;
      end while (jobDone !== 1'b1 && lat < 50);
      chk("zero_latency", 128'(lat), 128'(SETTLE + 2));
      chk("zero_sum", 128'(jobSum), 128'd0);
      chk("zero_writes", 128'(n_wr - d_wr), 128'd0);
      step();

      // Credit limit: results withheld, then released one at a time.
      d_done = n_done; d_wr = n_wr;
      fill(10, 48'd3, -1);
      rel_limit = res_rd;
      start_job(128'hC0DE_0000_0000_0000_0000_0000_0000_0001, 10, 1'b0);
      repeat (30) step();
      chk("credit_writes_blocked", 128'(n_wr - d_wr), 128'd4);
      chk("credit_ready_low", 128'(botInReady), 128'd0);
      chk("credit_outstanding_full", 128'(outstanding), 128'd4);
      rel_limit = res_rd + 1;
      repeat (20) step();
      chk("credit_one_more_write", 128'(n_wr - d_wr), 128'd5);
      chk("credit_outstanding_refull", 128'(outstanding), 128'd4);
      rel_limit = BIG;
      wait_done(400, ok);
      chk("credit_done_seen", 128'(ok), 128'd1);
      step();
      chk("credit_sum", 128'(jobSum), 128'd165);
      chk("credit_count_sum", 128'(jobCountSum), 128'd55);
      chk("credit_done_pulses", 128'(n_done - d_done), 128'd1);

      // Async reset in the middle of FEED.
      fill(6, 48'd4, -1);
      rel_limit = res_rd;
      start_job(128'hFEED_FEED_FEED_FEED_FEED_FEED_FEED_FEED, 6, 1'b0);
      repeat (15) step();
      d_done = n_done;
      rst_n = 1'b0;
      #1;
      chk("arst_top", pipeTop, 128'd0);
      chk("arst_bot", pipeBot, 128'd0);
      chk("arst_outstanding", 128'(outstanding), 128'd0);
      chk("arst_ready", 128'(jobReady), 128'd1);
      chk("arst_ready_bot", 128'(botInReady), 128'd0);
      rst_n = 1'b1;
      feed_n = 0; feed_gen++;
      rel_limit = BIG;
      repeat (12) step();
      chk("arst_no_done", 128'(n_done - d_done), 128'd0);
      v2 = '{128'h2222_0000_0000_0000_0000_0000_0000_0002, 2, 48'd11, 1'b0, -1,
             64'd33, 29'd3, 1'b0};
      run_vec(v2, "post_reset");

      // jobStart while busy must not disturb the running job.
      d_done = n_done; d_wr = n_wr;
      fill(3, 48'd5, -1);
      rel_limit = BIG;
      start_job(128'hB5B5_0000_0000_0000_0000_0000_0000_0003, 3, 1'b0);
      repeat (3) step();
      jobStart = 1'b1; jobTop = 128'h9999; jobBotCount = BCW'(9);
      step();
      jobStart = 1'b0;
      chk("busy_top_held", pipeTop, 128'hB5B5_0000_0000_0000_0000_0000_0000_0003);
      wait_done(400, ok);
      chk("busy_done_seen", 128'(ok), 128'd1);
      step();
      chk("busy_writes", 128'(n_wr - d_wr), 128'd3);
      chk("busy_sum", 128'(jobSum), 128'd30);
      chk("busy_done_pulses", 128'(n_done - d_done), 128'd1);
      chk("busy_top_after", pipeTop, 128'hB5B5_0000_0000_0000_0000_0000_0000_0003);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
